// File: rtl/instr_sequencer.sv
// Program buffer and replay sequencer feeding 12-bit instruction words to the mini CPU.
// Optional single-step issue control is enabled by defining INSTR_SEQ_STEP_EN.
module instr_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter logic [3:0]  HALT_OP  = 4'hF,
  parameter logic [11:0] NOP_WORD = 12'h000
) (
  input  logic              Clock,
  input  logic              CLR,
  input  logic              wr_en,
  input  logic [11:0]       wr_data,
  input  logic              prog_clr,
  input  logic              start,
  input  logic              stop,
`ifdef INSTR_SEQ_STEP_EN
  input  logic              step,
`endif
  output logic [11:0]       Instr,
  output logic              Instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   prog_len,
  output logic              full,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [ADDR_W:0] DepthLen = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [11:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W:0]   pc_q, pc_d;     // one extra bit so a full buffer can reach DEPTH
  logic [ADDR_W:0]   len_q, len_d;
  logic              done_q, done_d;
  logic              halt_q, halt_d; // last issued word carried HALT_OP
  logic              mem_we;
  logic              issue;
  logic [11:0]       rd_word;
  logic [11:0]       mem_q [DEPTH];

`ifdef INSTR_SEQ_STEP_EN
  assign issue = step;
`else
  assign issue = 1'b1;
`endif

  assign full    = (len_q == DepthLen);
  assign rd_word = mem_q[pc_q[ADDR_W-1:0]];

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    len_d   = len_q;
    done_d  = 1'b0;
    halt_d  = halt_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len_q != '0) begin
            instr_d = mem_q[0];
            valid_d = 1'b1;
            pc_d    = (ADDR_W+1)'(1);
            halt_d  = (mem_q[0][11:8] == HALT_OP);
            state_d = StRun;
          end
        end else if (prog_clr) begin
          len_d = '0;
        end else if (wr_en && !full) begin
          mem_we = 1'b1;
          len_d  = len_q + 1'b1;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          pc_d    = '0;
        end else if ((pc_q == len_q) || halt_q) begin
          state_d = StDone;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else if (issue) begin
          instr_d = rd_word;
          valid_d = 1'b1;
          pc_d    = pc_q + 1'b1;
          halt_d  = (rd_word[11:8] == HALT_OP);
        end else begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
        pc_d    = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (CLR) begin
      state_q <= StIdle;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      pc_q    <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      done_q  <= done_d;
      halt_q  <= halt_d;
    end
  end

  // Program storage needs no reset; prog_len decides which words are live.
  always_ff @(posedge Clock) begin
    if (mem_we && !CLR) begin
      mem_q[len_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  assign Instr       = instr_q;
  assign Instr_valid = valid_q;
  assign pc          = pc_q[ADDR_W-1:0];
  assign prog_len    = len_q;
  assign busy        = (state_q == StRun);
  assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (default DEPTH=16 build).
// Step-mode vectors are included when INSTR_SEQ_STEP_EN is defined.
module tb_instr_sequencer;

  logic        Clock = 1'b0;
  logic        CLR, wr_en, prog_clr, start, stop;
  logic [11:0] wr_data;
  logic [11:0] Instr;
  logic        Instr_valid, full, busy, done;
  logic [3:0]  pc;
  logic [4:0]  prog_len;
`ifdef INSTR_SEQ_STEP_EN
  logic        step;
`endif

  int errors = 0;
  int checks = 0;

  instr_sequencer dut (
    .Clock       (Clock),
    .CLR         (CLR),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .prog_clr    (prog_clr),
    .start       (start),
    .stop        (stop),
`ifdef INSTR_SEQ_STEP_EN
    .step        (step),
`endif
    .Instr       (Instr),
    .Instr_valid (Instr_valid),
    .pc          (pc),
    .prog_len    (prog_len),
    .full        (full),
    .busy        (busy),
    .done        (done)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [11:0] w);
    wr_en = 1'b1;
    wr_data = w;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic clear_prog();
    prog_clr = 1'b1;
    tick();
    prog_clr = 1'b0;
  endtask

  initial begin
    CLR = 1'b1; wr_en = 1'b0; wr_data = '0; prog_clr = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef INSTR_SEQ_STEP_EN
    step = 1'b1;
`endif
    tick();
    tick();
    check("rst_instr", 16'(Instr), 16'h000);
    check("rst_len", 16'(prog_len), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_valid", 16'(Instr_valid), 16'd0);
    check("rst_pc", 16'(pc), 16'd0);
    CLR = 1'b0;

    // Basic load and run
    write_word(12'h00A);
    write_word(12'h10B);
    write_word(12'h203);
    check("load_len", 16'(prog_len), 16'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_w0", 16'(Instr), 16'h00A);
    check("run_v0", 16'(Instr_valid), 16'd1);
    check("run_busy", 16'(busy), 16'd1);
    check("run_pc1", 16'(pc), 16'd1);
    tick();
    check("run_w1", 16'(Instr), 16'h10B);
    tick();
    check("run_w2", 16'(Instr), 16'h203);
    check("run_v2", 16'(Instr_valid), 16'd1);
    tick();
    check("run_done", 16'(done), 16'd1);
    check("run_end_instr", 16'(Instr), 16'h000);
    check("run_end_valid", 16'(Instr_valid), 16'd0);
    check("run_end_busy", 16'(busy), 16'd0);
    tick();
    check("run_done_drop", 16'(done), 16'd0);
    check("run_pc_zero", 16'(pc), 16'd0);
    check("run_len_kept", 16'(prog_len), 16'd3);

    // Halt word is issued, following word is not
    clear_prog();
    check("clr_len", 16'(prog_len), 16'd0);
    write_word(12'h111);
    write_word(12'hF00);
    write_word(12'h222);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("halt_w0", 16'(Instr), 16'h111);
    tick();
    check("halt_w1", 16'(Instr), 16'hF00);
    tick();
    check("halt_done", 16'(done), 16'd1);
    check("halt_instr", 16'(Instr), 16'h000);
    tick();
    check("halt_idle", 16'(busy), 16'd0);

    // Fill past capacity
    clear_prog();
    for (int i = 0; i < 17; i++) begin
      write_word(12'h300 + 12'(i));
      if (i == 14) check("full_at15", 16'(full), 16'd0);
      if (i == 15) check("full_at16", 16'(full), 16'd1);
    end
    check("full_len", 16'(prog_len), 16'd16);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_w%0d", i), 16'(Instr), 16'h300 + 16'(i));
      if (i < 15) tick();
    end
    check("full_pc_wrap", 16'(pc), 16'd0);
    tick();
    check("full_done", 16'(done), 16'd1);
    tick();
    check("full_after", 16'(busy), 16'd0);

    // Stop on second run cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    check("stop_w0", 16'(Instr), 16'h300);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_instr", 16'(Instr), 16'h000);
    check("stop_valid", 16'(Instr_valid), 16'd0);
    check("stop_busy", 16'(busy), 16'd0);
    check("stop_pc", 16'(pc), 16'd0);
    check("stop_nodone", 16'(done), 16'd0);
    tick();
    check("stop_nodone2", 16'(done), 16'd0);

    // start beats wr_en
    clear_prog();
    write_word(12'h055);
    start = 1'b1; wr_en = 1'b1; wr_data = 12'h777;
    tick();
    start = 1'b0; wr_en = 1'b0;
    check("prio_len", 16'(prog_len), 16'd1);
    check("prio_instr", 16'(Instr), 16'h055);
    tick();
    check("prio_done", 16'(done), 16'd1);
    tick();

    // start on empty program does nothing
    clear_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_busy", 16'(busy), 16'd0);
    check("empty_valid", 16'(Instr_valid), 16'd0);

    // Reset mid-run
    write_word(12'h0C1);
    write_word(12'h0C2);
    start = 1'b1;
    tick();
    start = 1'b0;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("mid_rst_len", 16'(prog_len), 16'd0);
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_instr", 16'(Instr), 16'h000);

`ifdef INSTR_SEQ_STEP_EN
    write_word(12'hA01);
    write_word(12'hA02);
    write_word(12'hA03);
    step = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("step_w0", 16'(Instr), 16'hA01);
    step = 1'b1;
    tick();
    check("step_w1", 16'(Instr), 16'hA02);
    check("step_pc2", 16'(pc), 16'd2);
    step = 1'b0;
    tick();
    check("step_nop_a", 16'(Instr), 16'h000);
    check("step_nov_a", 16'(Instr_valid), 16'd0);
    check("step_hold_a", 16'(pc), 16'd2);
    tick();
    check("step_nop_b", 16'(Instr), 16'h000);
    check("step_hold_b", 16'(pc), 16'd2);
    step = 1'b1;
    tick();
    check("step_w2", 16'(Instr), 16'hA03);
    check("step_v2", 16'(Instr_valid), 16'd1);
    step = 1'b0;
    tick();
    check("step_done", 16'(done), 16'd1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
